// File: rtl/shift_left_ctrl.sv
// Two-client round-robin front end for the 96-bit, 8-lane shift_left unit.
// Requests of up to 8 lanes are split into passes of at most 5 lanes each.

module shift_left (
    input  logic [95:0] word,
    input  logic [2:0]  shift,
    input  logic [11:0] fill,
    output logic [95:0] result,
    output logic        out_valid
);
    logic [191:0] ext;

    // The word sits above eight fill lanes, so each output lane reads from
    // 'shift' lanes lower in this extended vector.
    assign ext       = {word, {8{fill}}};
    assign out_valid = (shift <= 3'd5);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] base;
            assign base = 8'(96 + 12 * gi) - 8'(12 * shift);
            assign result[12*gi +: 12] = ext[base +: 12];
        end
    endgenerate
endmodule

module shift_left_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [95:0] req0_data,
    input  logic [3:0]  req0_amt,
    input  logic [11:0] req0_fill,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [95:0] req1_data,
    input  logic [3:0]  req1_amt,
    input  logic [11:0] req1_fill,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [95:0] resp_data,
    output logic        resp_id,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_reg, state_next;
    logic        rr_reg, rr_next;
    logic [3:0]  rem_reg, rem_next;
    logic [95:0] data_reg, data_next;
    logic [11:0] fill_reg, fill_next;
    logic        id_reg, id_next;

    logic        grant0, grant1;
    logic [2:0]  step;
    logic [95:0] shifted;
    logic        unit_valid;

    assign grant0 = req0_valid & (~req1_valid | ~rr_reg);
    assign grant1 = req1_valid & (~req0_valid |  rr_reg);

    // Outputs are forced low while reset is held, not just after the edge.
    assign req0_ready = rst_n & (state_reg == IDLE) & grant0;
    assign req1_ready = rst_n & (state_reg == IDLE) & grant1;
    assign resp_valid = rst_n & (state_reg == DONE);
    assign busy       = rst_n & (state_reg != IDLE);
    assign resp_data  = data_reg;
    assign resp_id    = id_reg;

    always_comb begin
        step = 3'd0;
        if (state_reg == RUN) begin
            step = (rem_reg > 4'd5) ? 3'd5 : rem_reg[2:0];
        end
    end

    shift_left u_shift (
        .word      (data_reg),
        .shift     (step),
        .fill      (fill_reg),
        .result    (shifted),
        .out_valid (unit_valid)
    );

    always_comb begin
        state_next = state_reg;
        rr_next    = rr_reg;
        rem_next   = rem_reg;
        data_next  = data_reg;
        fill_next  = fill_reg;
        id_next    = id_reg;
        case (state_reg)
            IDLE: begin
                if (req0_ready) begin
                    data_next  = req0_data;
                    fill_next  = req0_fill;
                    rem_next   = req0_amt[3] ? 4'd8 : req0_amt;
                    id_next    = 1'b0;
                    rr_next    = 1'b1;
                    state_next = RUN;
                end else if (req1_ready) begin
                    data_next  = req1_data;
                    fill_next  = req1_fill;
                    rem_next   = req1_amt[3] ? 4'd8 : req1_amt;
                    id_next    = 1'b1;
                    rr_next    = 1'b0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (unit_valid) begin
                    data_next = shifted;
                end
                rem_next = rem_reg - {1'b0, step};
                if (rem_next == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            rr_reg    <= 1'b0;
            rem_reg   <= 4'd0;
            data_reg  <= 96'd0;
            fill_reg  <= 12'd0;
            id_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
            rem_reg   <= rem_next;
            data_reg  <= data_next;
            fill_reg  <= fill_next;
            id_reg    <= id_next;
        end
    end
endmodule
